shift_deserializer: RTL
=======================

Name: shift_deserializer

Overview:
Serial-to-parallel receiver. It is the far end of the serial link driven by the team's universal shift register in shift mode. It collects a framed bit stream, one qualified bit per clock, into WIDTH-bit words and presents each word on a valid/ready parallel output. Direction is per frame: MSB-first (left shift) or LSB-first (right shift), matching the two shift modes of the transmitter.

Parameters:
WIDTH, 8, word length in bits; legal range is WIDTH >= 2.

Ports:
clk  input  1  single clock; all state updates on posedge clk
reset  input  1  synchronous, active-low reset; reset==0 at a posedge clears all state
sin  input  1  serial data bit
sin_valid  input  1  sin carries a bit this cycle
sin_start  input  1  first bit of a frame; only meaningful with sin_valid=1
msb_first  input  1  frame direction; sampled only with the start bit
q  output  WIDTH  assembled word
q_valid  output  1  q holds an undelivered word
q_ready  input  1  consumer accepts q this cycle
busy  output  1  a frame is in progress (state != IDLE)
overrun  output  1  sticky: a completed word was dropped

Behaviour:
- Reset: state=IDLE, shift reg=0, bit count=0, q=0, q_valid=0, busy=0, overrun=0.
  - A partial frame is discarded. A pending q is cleared.
- States: IDLE, SHIFT (plus PARITY when the macro below is enabled).
- IDLE:
  - sin_valid=1 with sin_start=0: ignored.
  - sin_valid=1 with sin_start=1: shift in the bit, latch msb_first into dir, count=1, go to SHIFT.
- SHIFT:
  - sin_valid=0: stall; hold all state.
  - sin_valid=1: shift in the bit, count+1.
  - sin_valid=1 with sin_start=1: abort the partial word and restart. This bit is the first bit; count=1; dir re-latched.
- Shift rule:
  - dir=1: sr <= {sr[WIDTH-2:0], sin}. The first bit lands in q[WIDTH-1].
  - dir=0: sr <= {sin, sr[WIDTH-1:1]}. The first bit lands in q[0].
- Completion (the WIDTH-th bit accepted): state returns to IDLE, so a new sin_start is accepted on the very next cycle.
  - Output slot free (q_valid=0, or q_valid=1 with q_ready=1 this cycle): q <= the assembled word and q_valid=1, visible the cycle after the last bit. Latency is 1 clk.
  - Slot occupied and q_ready=0: the word is dropped, q is unchanged, overrun <= 1. overrun stays 1 until reset.
- Output handshake:
  - q and q_valid are held stable while q_valid=1 and q_ready=0.
  - After q_valid & q_ready, q_valid falls the next cycle, unless a new word loads on the same edge; then q_valid stays 1 and q updates (back-to-back delivery).
- busy is registered and equals (state != IDLE).
- Count never exceeds WIDTH. Completion of one word and the start of the next frame cannot overlap because of the IDLE pass.

Optional Feature:
Macro DESER_PARITY_EN.
- Defined:
  - After the WIDTH-th data bit, the FSM enters PARITY and waits for one more qualified bit, which is even parity (XOR of the data bits).
  - Completion moves to that parity bit, so latency is 1 clk after the parity bit.
  - Adds output parity_err (1 bit, registered). It loads with q and is valid while q_valid=1; 1 means the XOR of data and parity is nonzero.
  - sin_start in PARITY restarts the frame. Overrun rules are unchanged.
- Not defined: no PARITY state and no parity_err port; behaviour is exactly as above.

Test Plan:
1. Reset: hold reset=0 for 2 clks with random sin/sin_valid, then reset=1 -> q=8'h00, q_valid=0, busy=0, overrun=0.
2. MSB-first: msb_first=1, bits 1,1,1,1,0,1,1,0 on consecutive cycles, sin_start on the first, q_ready=1 -> one clk after bit 8, q=8'hF6 and q_valid=1 for exactly 1 clk; busy high for 7 clks.
3. LSB-first with gaps: msb_first=0, bits 0,1,1,0,1,1,1,1, sin_valid=0 for 2 clks after bit 3 -> q=8'hF6 with q_valid delayed by 2 clks relative to scenario 2.
4. Overrun/backpressure: q_ready=0, send 8'hF6 then 8'h3C MSB-first -> q stays 8'hF6 and overrun=1 after the second frame. Then q_ready=1 -> q_valid falls next clk; overrun remains 1.
5. Restart and reset mid-frame:
   - sin_start reasserted at bit 5 with new frame 8'hA5 -> q=8'hA5 only.
   - reset=0 at bit 4 of a frame -> no q_valid, busy=0.
6. Parity (DESER_PARITY_EN): 8'hF6 with parity bit 0 -> parity_err=0; with parity bit 1 -> parity_err=1; q=8'hF6 in both cases.

Source files
------------

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: framed MSB- or LSB-first bits into WIDTH-bit words on a valid/ready output.
// Optional even-parity trailer bit and parity_err output when DESER_PARITY_EN is defined.
module shift_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_start,
  input  logic             msb_first,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
`ifdef DESER_PARITY_EN
  output logic             parity_err,
`endif
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef DESER_PARITY_EN
    ,PARITY = 2'd2
`endif
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] sr_r;
  logic             dir_r;
  logic [CW-1:0]    count_r;

  logic [WIDTH-1:0] word_s;
  logic [WIDTH-1:0] start_word_s;
  logic             slot_free_s;
  logic             last_s;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                input logic dir, input logic b);
    if (dir) begin
      return {sr[WIDTH-2:0], b};
    end else begin
      return {b, sr[WIDTH-1:1]};
    end
  endfunction

`ifdef DESER_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  assign word_s       = shift_in(sr_r, dir_r, sin);
  assign start_word_s = shift_in(sr_r, msb_first, sin);
  assign slot_free_s  = !q_valid || q_ready;
  assign last_s       = (count_r == CW'(WIDTH - 1));

  // Frame FSM, shift register and registered output slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      sr_r    <= '0;
      dir_r   <= 1'b0;
      count_r <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
`ifdef DESER_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (q_valid && q_ready) begin
        q_valid <= 1'b0;
      end
      // A start bit (re)opens a frame from any state; it is always bit one.
      if (sin_valid && sin_start) begin
        sr_r    <= start_word_s;
        dir_r   <= msb_first;
        count_r <= CW'(1);
        state_r <= SHIFT;
        busy    <= 1'b1;
      end else if (sin_valid) begin
        case (state_r)
          SHIFT: begin
            sr_r <= word_s;
            if (last_s) begin
`ifdef DESER_PARITY_EN
              count_r <= CW'(WIDTH);
              state_r <= PARITY;
`else
              count_r <= '0;
              state_r <= IDLE;
              busy    <= 1'b0;
              if (slot_free_s) begin
                q       <= word_s;
                q_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
`endif
            end else begin
              count_r <= count_r + CW'(1);
            end
          end
`ifdef DESER_PARITY_EN
          PARITY: begin
            count_r <= '0;
            state_r <= IDLE;
            busy    <= 1'b0;
            if (slot_free_s) begin
              q          <= sr_r;
              q_valid    <= 1'b1;
              parity_err <= even_parity(sr_r) ^ sin;
            end else begin
              overrun <= 1'b1;
            end
          end
`endif
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
